soc_noc_loopback_endpoint: RTL and testbench



---
 rtl/soc_noc_loopback_pkg.sv | 31 +++
 rtl/soc_noc_loopback_buffer.sv | 26 ++
 rtl/soc_noc_loopback_endpoint.sv | 144 ++++++++++++++
 tb/tb_soc_noc_loopback_endpoint.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/soc_noc_loopback_pkg.sv
// Shared types, header field constants and the header swap helper.
package soc_noc_loopback_pkg;

    localparam int HDR_FIELD_W  = 5;
    localparam int HDR_WORD_W   = 32;
    localparam int DEST_MSB_DEF = 31;
    localparam int SRC_MSB_DEF  = 23;

    typedef enum logic {
        RECV = 1'b0,
        SEND = 1'b1
    } state_t;

    // Both fields sit in the low 32-bit header word; all other bits pass through.
    function automatic logic [HDR_WORD_W-1:0] hdr_swap(
        input logic [HDR_WORD_W-1:0] flit,
        input int                    dest_msb,
        input int                    src_msb
    );
        logic [HDR_WORD_W-1:0]  res;
        logic [HDR_FIELD_W-1:0] dest;
        logic [HDR_FIELD_W-1:0] src;
        dest = flit[dest_msb -: HDR_FIELD_W];
        src  = flit[src_msb  -: HDR_FIELD_W];
        res  = flit;
        res[dest_msb -: HDR_FIELD_W] = src;
        res[src_msb  -: HDR_FIELD_W] = dest;
        return res;
    endfunction

endpackage

// File: rtl/soc_noc_loopback_buffer.sv
// Packet buffer: BUF_FLITS x FLIT_WIDTH registers, sync write, async read.
// Latency: write visible the cycle after wr_en; read is combinational. No backpressure.
module soc_noc_loopback_buffer #(
    parameter int FLIT_WIDTH = 32,
    parameter int BUF_FLITS  = 16,
    parameter int AW         = $clog2(BUF_FLITS)
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [AW-1:0]         wr_addr,
    input  logic [FLIT_WIDTH-1:0] wr_dat,
    input  logic [AW-1:0]         rd_addr,
    output logic [FLIT_WIDTH-1:0] rd_dat
);

    logic [FLIT_WIDTH-1:0] mem [BUF_FLITS];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_dat;
        end
    end

    assign rd_dat = mem[rd_addr];

endmodule

// File: rtl/soc_noc_loopback_endpoint.sv
// NoC loopback endpoint: buffers one packet, swaps dest/src in the header, replays it.
// Latency: first replay flit valid 1 cycle after in_last accepted. Input never stalls in RECV;
// replay holds while out_ready=0. Optional SOC_NOC_LOOPBACK_DROP_EN adds drop_mode (pure sink).
module soc_noc_loopback_endpoint
    import soc_noc_loopback_pkg::*;
#(
    parameter int FLIT_WIDTH = 32,
    parameter int BUF_FLITS  = 16,
    parameter int DEST_MSB   = DEST_MSB_DEF,
    parameter int SRC_MSB    = SRC_MSB_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
`ifdef SOC_NOC_LOOPBACK_DROP_EN
    input  logic                  drop_mode,
`endif
    input  logic [FLIT_WIDTH-1:0] in_flit,
    input  logic                  in_last,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [FLIT_WIDTH-1:0] out_flit,
    output logic                  out_last,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [15:0]           pkt_count,
    output logic                  err_oversize
);

    localparam int AW = $clog2(BUF_FLITS);
    localparam int PW = AW + 1;
    localparam logic [PW-1:0] FULL = PW'(BUF_FLITS);
    localparam logic [PW-1:0] ONE  = PW'(1);

    state_t                state_q, state_d;
    logic [PW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;
    logic [PW-1:0]         len;
    logic [15:0]           pkt_cnt_q;
    logic                  err_q;
    logic                  drop;
    logic                  in_hs, out_hs, buf_full, wr_en, end_in;
    logic [FLIT_WIDTH-1:0] rd_dat;
    logic [FLIT_WIDTH-1:0] hdr_dat;

`ifdef SOC_NOC_LOOPBACK_DROP_EN
    assign drop = drop_mode;
`else
    assign drop = 1'b0;
`endif

    assign in_ready  = (state_q == RECV) && !rst;
    assign out_valid = (state_q == SEND);
    assign in_hs     = in_valid && in_ready;
    assign out_hs    = out_valid && out_ready;
    assign buf_full  = (wr_ptr == FULL);
    assign wr_en     = in_hs && !buf_full;
    assign end_in    = in_hs && in_last;

    soc_noc_loopback_buffer #(
        .FLIT_WIDTH (FLIT_WIDTH),
        .BUF_FLITS  (BUF_FLITS),
        .AW         (AW)
    ) u_buf (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_addr (wr_ptr[AW-1:0]),
        .wr_dat  (in_flit),
        .rd_addr (rd_ptr),
        .rd_dat  (rd_dat)
    );

    generate
        if (FLIT_WIDTH > HDR_WORD_W) begin : g_hdr_wide
            assign hdr_dat = {rd_dat[FLIT_WIDTH-1:HDR_WORD_W],
                              hdr_swap(rd_dat[HDR_WORD_W-1:0], DEST_MSB, SRC_MSB)};
        end else begin : g_hdr_narrow
            assign hdr_dat = hdr_swap(rd_dat, DEST_MSB, SRC_MSB);
        end
    endgenerate

    always_comb begin
        out_flit = '0;
        out_last = 1'b0;
        if (state_q == SEND) begin
            out_flit = (rd_ptr == '0) ? hdr_dat : rd_dat;
            out_last = ({1'b0, rd_ptr} == (len - ONE));
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            RECV:    if (end_in && !drop)     state_d = SEND;
            SEND:    if (out_hs && out_last)  state_d = RECV;
            default: state_d = RECV;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= RECV;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            len       <= '0;
            pkt_cnt_q <= '0;
            err_q     <= 1'b0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + ONE;
            end
            // A discarded overflow flit still terminates the packet.
            if (end_in) begin
                len <= buf_full ? wr_ptr : (wr_ptr + ONE);
                if (drop) begin
                    wr_ptr    <= '0;
                    pkt_cnt_q <= pkt_cnt_q + 16'd1;
                end
            end
            if (in_hs && buf_full && !in_last) begin
                err_q <= 1'b1;
            end
            if (out_hs) begin
                if (out_last) begin
                    rd_ptr    <= '0;
                    wr_ptr    <= '0;
                    pkt_cnt_q <= pkt_cnt_q + 16'd1;
                end else begin
                    rd_ptr <= rd_ptr + 1'b1;
                end
            end
        end
    end

    assign pkt_count    = pkt_cnt_q;
    assign err_oversize = err_q;

endmodule

// File: tb/tb_soc_noc_loopback_endpoint.sv
// Directed scoreboard bench for soc_noc_loopback_endpoint (default build, 32-bit flits, 16-deep).
module tb_soc_noc_loopback_endpoint;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] in_flit = '0;
    logic        in_last = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] out_flit;
    logic        out_last;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [15:0] pkt_count;
    logic        err_oversize;

    int n_vec = 0;
    int n_err = 0;
    int hs_cnt = 0;
    bit bp_en = 1'b0;

    logic [31:0] stim_flit[$];
    logic [31:0] exp_flit[$];
    logic        exp_last[$];

    soc_noc_loopback_endpoint dut (
        .clk          (clk),
        .rst          (rst),
        .in_flit      (in_flit),
        .in_last      (in_last),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .out_flit     (out_flit),
        .out_last     (out_last),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .pkt_count    (pkt_count),
        .err_oversize (err_oversize)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    always @(posedge clk) begin
        #1;
        out_ready = bp_en ? ~out_ready : 1'b1;
    end

    // Monitor: pops the scoreboard at every handshake, checks stall stability.
    logic        prev_stall = 1'b0;
    logic [31:0] prev_flit = '0;
    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 1'b0;
        end else if (out_valid) begin
            if (in_ready !== 1'b0) chk("in_ready_during_replay", {31'd0, in_ready}, 32'd0);
            if (prev_stall) chk("stall_stable", out_flit, prev_flit);
            if (out_ready) begin
                hs_cnt++;
                if (exp_flit.size() == 0) begin
                    chk("unexpected_flit", out_flit, 32'hxxxx_xxxx);
                end else begin
                    chk("out_flit", out_flit, exp_flit.pop_front());
                    chk("out_last", {31'd0, out_last}, {31'd0, exp_last.pop_front()});
                end
            end
            prev_stall = !out_ready;
            prev_flit  = out_flit;
        end else begin
            if (prev_stall) chk("valid_withdrawn", {31'd0, out_valid}, 32'd1);
            prev_stall = 1'b0;
        end
    end

    task automatic expect_flit(input logic [31:0] f, input logic l);
        exp_flit.push_back(f);
        exp_last.push_back(l);
    endtask

    // Drives stim_flit as one packet, last flag on the final entry.
    task automatic send_pkt(input string name);
        int n;
        n = stim_flit.size();
        for (int i = 0; i < n; i++) begin
            in_flit  = stim_flit[i];
            in_last  = (i == n - 1);
            in_valid = 1'b1;
            @(negedge clk);
            chk({name, "_in_ready"}, {31'd0, in_ready}, 32'd1);
            chk({name, "_no_early_valid"}, {31'd0, out_valid}, 32'd0);
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        chk({name, "_latency"}, {31'd0, out_valid}, 32'd1);
        stim_flit.delete();
    endtask

    task automatic wait_drain(input string name);
        for (int i = 0; i < 400; i++) begin
            if (exp_flit.size() == 0) break;
            @(posedge clk);
        end
        chk({name, "_drained"}, exp_flit.size(), 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_flit", out_flit, 32'd0);
        chk("rst_pkt_count", {16'd0, pkt_count}, 32'd0);
        chk("rst_err", {31'd0, err_oversize}, 32'd0);
        rst = 1'b0;
        #1;
        chk("post_rst_in_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        #1;

        // Single flit: dest=1,src=0 -> src=1 at bits 23:19.
        expect_flit(32'h0008_0000, 1'b1);
        stim_flit = '{32'h0800_0000};
        send_pkt("single");
        wait_drain("single");
        chk("single_pkt_count", {16'd0, pkt_count}, 32'd1);

        // Four flits: dest=2,src=6 header.
        expect_flit(32'h3214_5678, 1'b0);
        expect_flit(32'hA1A1_A1A1, 1'b0);
        expect_flit(32'hA2A2_A2A2, 1'b0);
        expect_flit(32'hA3A3_A3A3, 1'b1);
        stim_flit = '{32'h1234_5678, 32'hA1A1_A1A1, 32'hA2A2_A2A2, 32'hA3A3_A3A3};
        send_pkt("four");
        wait_drain("four");
        chk("four_pkt_count", {16'd0, pkt_count}, 32'd2);

        // Backpressure with out_ready toggling.
        bp_en = 1'b1;
        expect_flit(32'h00F8_0000, 1'b0);
        expect_flit(32'hC0DE_0001, 1'b0);
        expect_flit(32'hC0DE_0002, 1'b1);
        stim_flit = '{32'hF800_0000, 32'hC0DE_0001, 32'hC0DE_0002};
        send_pkt("bp");
        wait_drain("bp");
        bp_en = 1'b0;
        @(posedge clk);
        #1;
        chk("bp_pkt_count", {16'd0, pkt_count}, 32'd3);
        chk("bp_no_err", {31'd0, err_oversize}, 32'd0);

        // Oversize: 20 flits in, first 16 replayed.
        expect_flit(32'hFF07_FFFF, 1'b0);
        for (int i = 1; i < 16; i++) expect_flit(32'hB000_0000 + i, i == 15);
        stim_flit.push_back(32'h07FF_FFFF);
        for (int i = 1; i < 20; i++) stim_flit.push_back(32'hB000_0000 + i);
        send_pkt("oversize");
        chk("oversize_err", {31'd0, err_oversize}, 32'd1);
        wait_drain("oversize");
        chk("oversize_pkt_count", {16'd0, pkt_count}, 32'd4);
        chk("oversize_err_sticky", {31'd0, err_oversize}, 32'd1);

        // Reset after two of four replayed flits.
        expect_flit(32'h8008_0000, 1'b0);
        expect_flit(32'h5555_0001, 1'b0);
        expect_flit(32'h5555_0002, 1'b0);
        expect_flit(32'h5555_0003, 1'b1);
        stim_flit = '{32'h0880_0000, 32'h5555_0001, 32'h5555_0002, 32'h5555_0003};
        begin
            int base;
            bit hit;
            base = hs_cnt;
            hit  = 1'b0;
            send_pkt("rstmid");
            for (int i = 0; i < 50; i++) begin
                @(posedge clk);
                if (hs_cnt >= base + 2) begin
                    hit = 1'b1;
                    break;
                end
            end
            chk("rstmid_two_sent", {31'd0, hit}, 32'd1);
        end
        #1;
        rst = 1'b1;
        #1;
        exp_flit.delete();
        exp_last.delete();
        chk("rstmid_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rstmid_in_ready_low", {31'd0, in_ready}, 32'd0);
        chk("rstmid_err_clear", {31'd0, err_oversize}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("rstmid_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rstmid_pkt_count", {16'd0, pkt_count}, 32'd0);
        chk("rstmid_out_valid_after", {31'd0, out_valid}, 32'd0);
        @(posedge clk);
        #1;

        // Counter wrap from a forced 16'hFFFF.
        force dut.pkt_cnt_q = 16'hFFFF;
        @(posedge clk);
        #1;
        release dut.pkt_cnt_q;
        #1;
        chk("wrap_preload", {16'd0, pkt_count}, 32'h0000_FFFF);
        expect_flit(32'h0000_0ABC, 1'b1);
        stim_flit = '{32'h0000_0ABC};
        send_pkt("wrap");
        wait_drain("wrap");
        chk("wrap_pkt_count", {16'd0, pkt_count}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete, expected $finish");
        $fatal(1);
    end

endmodule
